// File: rtl/array_scan_pkg.sv
// Shared types and default sizing for the array scan sequencer.
package array_scan_pkg;

    localparam int DEF_MEM_W    = 12;
    localparam int DEF_N_AREA   = 10;
    localparam int DEF_N_ARRAYS = 2000;

    // Command opcodes carried on req_op.
    typedef enum logic [1:0] {
        OP_INDEX         = 2'd0,
        OP_COUNT_LESS    = 2'd1,
        OP_COUNT_GREATER = 2'd2,
        OP_RSVD          = 2'd3
    } op_t;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SIZE  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. A single requester always wins; when
// both request, the pointer decides, and the pointer moves to the other
// requester after every grant.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       resetn,
    input  logic       i_enable,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    logic r_ptr;

    // Grant selection: one-hot, only while enabled and only to a requester.
    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            if (i_req == 2'b11) begin
                o_grant = r_ptr ? 2'b10 : 2'b01;
            end else begin
                o_grant = i_req;
            end
        end
    end

    // Pointer update: a grant is always an accept, so favour the other side next.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= 1'b0;
        end else if (|o_grant) begin
            r_ptr <= ~o_grant[1];
        end
    end

endmodule

// File: rtl/array_scan_sequencer.sv
// Array scan sequencer: accepts one command at a time from two requesters,
// reads the array size, streams the array's heap words and reduces them into
// an index or a count, then presents the result until the consumer takes it.
//
// Handshakes: a command transfers on a cycle where req_valid[r] and
// req_ready[r] are both high; a result transfers on a cycle where rsp_valid
// and rsp_ready are both high. rsp_* stay stable while rsp_valid waits.
module array_scan_sequencer
    import array_scan_pkg::*;
#(
    parameter int MemoryElementWidth = DEF_MEM_W,
    parameter int NArea              = DEF_N_AREA,
    parameter int NArrays            = DEF_N_ARRAYS,
    localparam int W                 = MemoryElementWidth,
    localparam int AW                = $clog2(NArrays * NArea)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0][1:0]     req_op,
    input  logic [1:0][W-1:0]   req_array,
    input  logic [1:0][W-1:0]   req_key,
    output logic                size_rd,
    output logic [W-1:0]        size_addr,
    input  logic [W-1:0]        size_rdata,
    output logic                heap_rd,
    output logic [AW-1:0]       heap_addr,
    input  logic [W-1:0]        heap_rdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [W-1:0]        rsp_result,
    output logic                rsp_err
);

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    w_grant;
    logic          w_accept;
    logic          w_sel;

    op_t           r_op;
    logic [W-1:0]  r_array;
    logic [W-1:0]  r_key;
    logic          r_id;

    // r_loaded marks that the scan limit has been captured (first SCAN cycle
    // is spent sampling size_rdata).
    logic          r_loaded;
    logic [W-1:0]  r_n;
    logic [W-1:0]  r_idx;
    logic          r_pend;
    logic [W-1:0]  r_ret_idx;
    logic [W-1:0]  r_acc;

    logic [W-1:0]  w_limit;
    logic          w_issue;
    logic          w_last_issue;
    logic [AW-1:0] w_heap_addr;
    logic [W-1:0]  r_size_addr;
    logic [AW-1:0] r_heap_addr;

    rr_arbiter2 u_arb (
        .clock    (clock),
        .resetn   (resetn),
        .i_enable (r_state == ST_IDLE),
        .i_req    (req_valid),
        .o_grant  (w_grant)
    );

    assign w_accept     = |w_grant;
    assign w_sel        = w_grant[1];
    assign w_limit      = (size_rdata > W'(NArea)) ? W'(NArea) : size_rdata;
    assign w_issue      = (r_state == ST_SCAN) && r_loaded;
    assign w_last_issue = w_issue && (r_idx == (r_n - W'(1)));
    assign w_heap_addr  = (AW'(r_array) * AW'(NArea)) + AW'(r_idx);

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = ST_SIZE;
            ST_SIZE:  w_next = ST_SCAN;
            ST_SCAN: begin
                if (!r_loaded) begin
                    if (w_limit == '0) w_next = ST_DONE;
                end else if (w_last_issue) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: w_next = ST_DONE;
            ST_DONE:  if (rsp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: strobes, held addresses and the response.
    always_comb begin
        req_ready  = w_grant;
        size_rd    = (r_state == ST_SIZE);
        size_addr  = size_rd ? r_array : r_size_addr;
        heap_rd    = w_issue;
        heap_addr  = heap_rd ? w_heap_addr : r_heap_addr;
        rsp_valid  = (r_state == ST_DONE);
        rsp_id     = rsp_valid ? r_id : 1'b0;
        rsp_err    = rsp_valid && (r_op == OP_RSVD);
        rsp_result = (rsp_valid && (r_op != OP_RSVD)) ? r_acc : '0;
    end

    // Command latch on accept.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_op    <= OP_INDEX;
            r_array <= '0;
            r_key   <= '0;
            r_id    <= 1'b0;
        end else if (w_accept) begin
            r_op    <= op_t'(req_op[w_sel]);
            r_array <= req_array[w_sel];
            r_key   <= req_key[w_sel];
            r_id    <= w_sel;
        end
    end

    // Scan sequencing: capture the limit, then issue one heap read per cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_loaded  <= 1'b0;
            r_n       <= '0;
            r_idx     <= '0;
            r_pend    <= 1'b0;
            r_ret_idx <= '0;
        end else begin
            r_pend <= w_issue;
            if (r_state == ST_SIZE) begin
                r_loaded <= 1'b0;
            end else if ((r_state == ST_SCAN) && !r_loaded) begin
                r_loaded <= 1'b1;
                r_n      <= w_limit;
                r_idx    <= '0;
            end else if (w_issue) begin
                r_idx     <= r_idx + W'(1);
                r_ret_idx <= r_idx;
            end
        end
    end

    // Accumulator: fold each returned heap word into the result.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= '0;
        end else if (r_pend) begin
            case (r_op)
                OP_INDEX:         if (heap_rdata == r_key) r_acc <= r_ret_idx + W'(1);
                OP_COUNT_LESS:    if (heap_rdata <  r_key) r_acc <= r_acc + W'(1);
                OP_COUNT_GREATER: if (heap_rdata >  r_key) r_acc <= r_acc + W'(1);
                default:          r_acc <= r_acc;
            endcase
        end
    end

    // Address hold registers so addresses keep their last value when idle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_size_addr <= '0;
            r_heap_addr <= '0;
        end else begin
            if (size_rd) r_size_addr <= r_array;
            if (heap_rd) r_heap_addr <= w_heap_addr;
        end
    end

endmodule

// File: tb/tb_array_scan_sequencer.sv
// Self-checking bench for array_scan_sequencer with a scoreboard of
// expected {id, err, result} responses and a simple size/heap memory model.
module tb_array_scan_sequencer;

  localparam int W  = 12;
  localparam int AW = 15;
  localparam logic [1:0] OP_IDX = 2'd0;
  localparam logic [1:0] OP_LT  = 2'd1;
  localparam logic [1:0] OP_GT  = 2'd2;
  localparam logic [1:0] OP_RES = 2'd3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][1:0]   req_op;
  logic [1:0][W-1:0] req_array;
  logic [1:0][W-1:0] req_key;
  logic              size_rd;
  logic [W-1:0]      size_addr;
  logic [W-1:0]      size_rdata;
  logic              heap_rd;
  logic [AW-1:0]     heap_addr;
  logic [W-1:0]      heap_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_err;

  array_scan_sequencer dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_array  (req_array),
    .req_key    (req_key),
    .size_rd    (size_rd),
    .size_addr  (size_addr),
    .size_rdata (size_rdata),
    .heap_rd    (heap_rd),
    .heap_addr  (heap_addr),
    .heap_rdata (heap_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  // ---------------- memory model ----------------
  logic [W-1:0] size_mem [0:7];
  logic [W-1:0] heap_mem [0:63];

  initial begin
    for (int i = 0; i < 8; i++) size_mem[i] = '0;
    for (int i = 0; i < 64; i++) heap_mem[i] = '0;
    size_mem[0] = 12'd3;
    size_mem[1] = 12'd12;
    size_mem[2] = 12'd0;
    heap_mem[0] = 12'd10;
    heap_mem[1] = 12'd20;
    heap_mem[2] = 12'd30;
    for (int i = 10; i < 20; i++) heap_mem[i] = 12'd7;
    heap_mem[20] = 12'd1;
    heap_mem[21] = 12'd1;
    size_rdata = '0;
    heap_rdata = '0;
  end

  always @(posedge clock) begin
    if (size_rd) size_rdata <= (size_addr < 12'd8) ? size_mem[size_addr[2:0]] : '0;
    if (heap_rd) heap_rdata <= (heap_addr < 15'd64) ? heap_mem[heap_addr[5:0]] : '0;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [W+1:0] exp_q[$];
  int n_exp    = 0;
  int rsp_cnt  = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int heap_cnt = 0;
  logic prev_v = 1'b0;

  always @(posedge clock) cyc++;

  task automatic expect_rsp(input logic id, input logic err, input logic [W-1:0] res);
    exp_q.push_back({id, err, res});
    n_exp++;
  endtask

  always @(negedge clock) begin
    logic [W+1:0] e;
    if (resetn) begin
      if (heap_rd) heap_cnt++;
      if (rsp_valid && !prev_v) rise_cyc = cyc;
      if (req_ready != 2'b00) begin
        check("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
        check("ready_onehot", 32'($countones(req_ready)), 32'd1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e[W+1]));
          check("rsp_err", 32'(rsp_err), 32'(e[W]));
          check("rsp_result", 32'(rsp_result), 32'(e[W-1:0]));
        end
        rsp_cnt++;
      end
    end
    prev_v = rsp_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int r, input logic [1:0] op, input int arr, input int key, output int t_acc);
    t_acc = -1;
    @(posedge clock); #1;
    req_op[r]    = op;
    req_array[r] = W'(arr);
    req_key[r]   = W'(key);
    req_valid[r] = 1'b1;
    for (int b = 0; b < 200 && t_acc < 0; b++) begin
      @(negedge clock);
      if (req_ready[r]) t_acc = cyc;
    end
    @(posedge clock); #1;
    req_valid[r] = 1'b0;
    if (t_acc < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp();
    for (int b = 0; b < 300 && rsp_cnt < n_exp; b++) @(negedge clock);
    if (rsp_cnt < n_exp) check("rsp_timeout", 32'(rsp_cnt), 32'(n_exp));
  endtask

  task automatic run_cmd(input int r, input logic [1:0] op, input int arr, input int key,
                         input int res, input logic err, output int lat);
    int t;
    expect_rsp(r[0], err, W'(res));
    send(r, op, arr, key, t);
    wait_rsp();
    lat = rise_cyc - t;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_req_ready"},  32'(req_ready),  32'd0);
    check({pfx, "_size_rd"},    32'(size_rd),    32'd0);
    check({pfx, "_heap_rd"},    32'(heap_rd),    32'd0);
    check({pfx, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    check({pfx, "_rsp_id"},     32'(rsp_id),     32'd0);
    check({pfx, "_rsp_result"}, 32'(rsp_result), 32'd0);
    check({pfx, "_rsp_err"},    32'(rsp_err),    32'd0);
  endtask

  // ---------------- stimulus ----------------
  int idx_keys[4] = '{30, 20, 10, 15};
  int idx_res[4]  = '{3, 2, 1, 0};
  int cmp_keys[4] = '{35, 25, 15, 5};
  int lt_res[4]   = '{3, 2, 1, 0};
  int gt_res[4]   = '{0, 1, 2, 3};
  int r0_keys[3]  = '{10, 20, 30};
  int r1_keys[3]  = '{30, 20, 10};

  initial begin
    int lat;
    int t;
    int t1;
    resetn    = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_array = '0;
    req_key   = '0;
    rsp_ready = 1'b1;
    #3;
    check_outputs_zero("reset");
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    // Round robin: both requesters busy from reset, grants alternate from 0.
    expect_rsp(1'b0, 1'b0, 12'd1);
    expect_rsp(1'b1, 1'b0, 12'd3);
    expect_rsp(1'b0, 1'b0, 12'd2);
    expect_rsp(1'b1, 1'b0, 12'd2);
    expect_rsp(1'b0, 1'b0, 12'd3);
    expect_rsp(1'b1, 1'b0, 12'd1);
    fork
      begin
        int ta;
        for (int i = 0; i < 3; i++) send(0, OP_IDX, 0, r0_keys[i], ta);
      end
      begin
        int tb;
        for (int i = 0; i < 3; i++) send(1, OP_IDX, 0, r1_keys[i], tb);
      end
    join
    wait_rsp();

    // INDEX, then COUNT_LESS and COUNT_GREATER on array 0.
    for (int i = 0; i < 4; i++) begin
      run_cmd(0, OP_IDX, 0, idx_keys[i], idx_res[i], 1'b0, lat);
      if (i == 0) check("index_latency", 32'(lat), 32'd7);
    end
    for (int i = 0; i < 4; i++) run_cmd(0, OP_LT, 0, cmp_keys[i], lt_res[i], 1'b0, lat);
    for (int i = 0; i < 4; i++) run_cmd(1, OP_GT, 0, cmp_keys[i], gt_res[i], 1'b0, lat);

    // Size beyond NArea clips to 10 reads; size 0 skips the scan.
    heap_cnt = 0;
    run_cmd(0, OP_LT, 1, 8, 10, 1'b0, lat);
    check("clip_latency", 32'(lat), 32'd14);
    check("clip_heap_reads", 32'(heap_cnt), 32'd10);
    heap_cnt = 0;
    run_cmd(0, OP_IDX, 2, 0, 0, 1'b0, lat);
    check("empty_latency", 32'(lat), 32'd3);
    check("empty_heap_reads", 32'(heap_cnt), 32'd0);

    // Back-pressure on the response with a second requester waiting.
    @(posedge clock); #1 rsp_ready = 1'b0;
    expect_rsp(1'b0, 1'b0, 12'd2);
    send(0, OP_IDX, 0, 20, t);
    for (int b = 0; b < 50 && !rsp_valid; b++) @(negedge clock);
    expect_rsp(1'b1, 1'b1, 12'd0);
    fork
      send(1, OP_RES, 0, 10, t1);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_valid",  32'(rsp_valid),  32'd1);
      check("hold_id",     32'(rsp_id),     32'd0);
      check("hold_result", 32'(rsp_result), 32'd2);
      check("hold_ready",  32'(req_ready),  32'd0);
    end
    @(posedge clock); #1 rsp_ready = 1'b1;
    wait fork;
    wait_rsp();

    // Reset in the middle of a scan discards the command.
    send(0, OP_IDX, 0, 10, t);
    for (int b = 0; b < 50 && !heap_rd; b++) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    check("no_rsp_after_abort", 32'(rsp_cnt), 32'(n_exp));
    run_cmd(0, OP_IDX, 0, 20, 2, 1'b0, lat);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/array_scan_sequencer.md
ARRAY_SCAN_SEQUENCER -- requirements
Module: array_scan_sequencer

Interface
REQ-001 Parameter MemoryElementWidth, default 12, width of heap words, keys and results.
REQ-002 Parameter NArea, default 10, heap words per array.
REQ-003 Parameter NArrays, default 2000, number of arrays.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  2  per-requester command valid; bit r is requester r.
REQ-007 req_ready  output  2  per-requester command accepted this cycle.
REQ-008 req_op  input  2x2  per-requester opcode: 0 INDEX, 1 COUNT_LESS, 2 COUNT_GREATER, 3 reserved.
REQ-009 req_array  input  2xMemoryElementWidth  per-requester array number.
REQ-010 req_key  input  2xMemoryElementWidth  per-requester comparison key.
REQ-011 size_rd  output  1  array-size table read strobe.
REQ-012 size_addr  output  MemoryElementWidth  array number for size read.
REQ-013 size_rdata  input  MemoryElementWidth  size, valid the cycle after size_rd.
REQ-014 heap_rd  output  1  heap read strobe.
REQ-015 heap_addr  output  clog2(NArrays*NArea)  heap word address.
REQ-016 heap_rdata  input  MemoryElementWidth  heap word, valid the cycle after heap_rd.
REQ-017 rsp_valid  output  1  result valid.
REQ-018 rsp_ready  input  1  consumer accepts result.
REQ-019 rsp_id  output  1  requester that issued the command.
REQ-020 rsp_result  output  MemoryElementWidth  scan result.
REQ-021 rsp_err  output  1  reserved opcode was executed.

Function
REQ-022 FSM states IDLE, SIZE, SCAN, DRAIN, DONE; one command in flight at a time.
REQ-023 req_ready SHALL be asserted only in IDLE, for at most one requester, the granted one, and only when its req_valid is high.
REQ-024 Arbitration SHALL be round-robin: a pointer names the favoured requester; single request wins; both requesting -> favoured wins; pointer moves to the other requester after each grant.
REQ-025 On accept (cycle T) op, array, key, id are latched; IDLE->SIZE.
REQ-026 SIZE (T+1): size_rd=1, size_addr=latched array; ->SCAN.
REQ-027 SCAN: limit n = min(size_rdata, NArea) captured on entry; n=0 -> DONE directly.
REQ-028 SCAN issues heap_rd with heap_addr = array*NArea + i for i = 0..n-1, one per cycle, back-to-back; after last issue -> DRAIN.
REQ-029 Each returned word e_i (cycle after its read) updates accumulator: INDEX: e_i==key -> acc=i+1 (last match wins); COUNT_LESS: e_i<key -> acc+1; COUNT_GREATER: e_i>key -> acc+1; all compares unsigned.
REQ-030 DRAIN absorbs the final return word then ->DONE; result valid at T+4+n for n>0, T+3 for n=0.
REQ-031 Reserved opcode: scan still performed, rsp_result=0, rsp_err=1.
REQ-032 DONE: rsp_valid=1 with stable id/result/err until rsp_ready; handshake cycle -> IDLE; new command accepted no earlier than next cycle.
REQ-033 Accumulator width MemoryElementWidth; maximum value NArea, no overflow possible.
REQ-034 size_rd, heap_rd low outside SIZE/SCAN; addresses hold last value when strobe low.

Reset
REQ-035 resetn low SHALL immediately force: state IDLE, pointer favours requester 0, req_ready=0, size_rd=0, heap_rd=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, accumulator 0.
REQ-036 Reset mid-operation discards the in-flight command; no response is produced for it; read data arriving after reset is ignored.

Structure
REQ-037 Package array_scan_pkg SHALL hold opcode enum, FSM state enum and the default parameter values.
REQ-038 One sub-module rr_arbiter2 SHALL implement REQ-024 (grant vector, pointer update on accept).

Verification (array 0 = {10,20,30}, size 3, unless stated)
REQ-039 INDEX keys 30,20,10,15 from requester 0 -> results 3,2,1,0; first result at T+7.
REQ-040 COUNT_LESS keys 35,25,15,5 -> 3,2,1,0; COUNT_GREATER keys 35,25,15,5 -> 0,1,2,3.
REQ-041 Both requesters valid from reset, each 3 commands -> grant order 0,1,0,1,0,1; rsp_id matches.
REQ-042 Size table entry 12 with heap words all 7, COUNT_LESS key 8 -> result 10, exactly 10 heap_rd pulses; size 0 -> result 0 at T+3, no heap_rd.
REQ-043 rsp_ready held low 5 cycles -> outputs stable, req_ready low throughout; opcode 3 -> result 0, rsp_err=1.
REQ-044 resetn low during SCAN -> all outputs 0 same cycle; after release a new INDEX key 20 returns 2.
